// File: rtl/data_path_mc_if.sv
// data_path_mc_if: instruction- and data-memory request/ready buses of data_path_mc
interface data_path_mc_if #(
  parameter int XLEN = 32,
  parameter int MEM_AW = 8,
  parameter int IMEM_AW = 32
) ();
  logic imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic imem_ready;
  logic [31:0] imem_rdata;
  logic dmem_req;
  logic dmem_we;
  logic [MEM_AW-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic dmem_ready;
  logic [XLEN-1:0] dmem_rdata;
  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );
  modport slave (
    input imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/data_path_mc.sv
// data_path_mc: multi-cycle RV32 datapath with stallable imem/dmem handshakes; DATA_PATH_PERF_EN adds cycle/retire counters
module data_path_mc #(
  parameter int XLEN = 32,
  parameter int MEM_AW = 8,
  parameter int IMEM_AW = 32,
  parameter int RF_DEPTH = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rest,
  input  logic pc_sel,
  input  logic a_sel,
  input  logic b_sel,
  input  logic RF_we,
  input  logic [1:0] wb_sel,
  input  logic [2:0] imm_sel,
  input  logic [3:0] alu_sel,
  input  logic mem_rd,
  input  logic mem_wr,
  output logic [31:0] ins,
  output logic [XLEN-1:0] pc,
  output logic beq,
  output logic retire,
  output logic [1:0] state,
`ifdef DATA_PATH_PERF_EN
  output logic [63:0] cyc_cnt,
  output logic [63:0] ret_cnt,
`endif
  data_path_mc_if.master bus
);
  localparam int RA = $clog2(RF_DEPTH);
  localparam int SW = (XLEN == 64) ? 6 : 5;
  typedef enum logic [1:0] {FETCH, EXEC, MEM, WB} st_e;
  st_e st;
  logic [XLEN-1:0] rf [RF_DEPTH];
  logic [XLEN-1:0] rs1, rs2, imm, op_a, op_b, alu, alu_q, st_q, ld_q, pc4, wb_data;
  logic [31:0] imm32;
  logic [RA-1:0] ra1, ra2, rd;
  logic [SW-1:0] sh;
  logic mem_op;
  assign ra1 = ins[15 +: RA];
  assign ra2 = ins[20 +: RA];
  assign rd = ins[7 +: RA];
  assign rs1 = ra1 == '0 ? '0 : rf[ra1];
  assign rs2 = ra2 == '0 ? '0 : rf[ra2];
  assign beq = rs1 == rs2;
  assign pc4 = pc + XLEN'(4);
  assign mem_op = mem_rd | mem_wr;
  assign state = st;
  assign imm32 = imm_sel == 3'd0 ? {{20{ins[31]}}, ins[31:20]} :
                 imm_sel == 3'd1 ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
                 imm_sel == 3'd2 ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
                 imm_sel == 3'd3 ? {ins[31:12], 12'b0} :
                 imm_sel == 3'd4 ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} : '0;
  assign imm = XLEN'($signed(imm32));
  assign op_a = a_sel ? pc : rs1;
  assign op_b = b_sel ? imm : rs2;
  assign sh = op_b[SW-1:0];
  assign wb_data = wb_sel[1] ? pc4 : wb_sel[0] ? alu_q : ld_q;
  assign bus.imem_addr = pc[IMEM_AW-1:0];
  assign bus.dmem_addr = alu_q[MEM_AW-1:0];
  assign bus.dmem_wdata = st_q;
  // ALU: unsupported opcodes yield zero
  always_comb begin
    alu = '0;
    case (alu_sel)
      4'd0: alu = op_a + op_b;
      4'd1: alu = op_a - op_b;
      4'd2: alu = op_a << sh;
      4'd3: alu = XLEN'($signed(op_a) < $signed(op_b));
      4'd4: alu = XLEN'(op_a < op_b);
      4'd5: alu = op_a ^ op_b;
      4'd6: alu = op_a >> sh;
      4'd7: alu = $signed(op_a) >>> sh;
      4'd8: alu = op_a | op_b;
      4'd9: alu = op_a & op_b;
      4'd10: alu = op_b;
      default: alu = '0;
    endcase
  end
  // register file write in WB; contents survive reset, x0 never written
  always_ff @(posedge clk)
    if (!rest && st == WB && RF_we && rd != '0) rf[rd] <= wb_data;
  // sequencer: FETCH -> EXEC -> [MEM] -> WB, requests and retire registered
  always_ff @(posedge clk) begin
    if (rest) begin
      st <= FETCH;
      pc <= RESET_PC;
      ins <= 32'h0000_0013;
      bus.imem_req <= 1'b0;
      bus.dmem_req <= 1'b0;
      bus.dmem_we <= 1'b0;
      retire <= 1'b0;
      alu_q <= '0;
      st_q <= '0;
      ld_q <= '0;
    end else begin
      retire <= 1'b0;
      case (st)
        FETCH: if (bus.imem_req && bus.imem_ready) begin
          ins <= bus.imem_rdata;
          bus.imem_req <= 1'b0;
          st <= EXEC;
        end else bus.imem_req <= 1'b1;
        EXEC: begin
          alu_q <= alu;
          st_q <= rs2;
          bus.dmem_req <= mem_op;
          bus.dmem_we <= mem_wr;
          retire <= !mem_op;
          st <= mem_op ? MEM : WB;
        end
        MEM: if (bus.dmem_ready) begin
          if (!bus.dmem_we) ld_q <= bus.dmem_rdata;
          bus.dmem_req <= 1'b0;
          bus.dmem_we <= 1'b0;
          retire <= 1'b1;
          st <= WB;
        end
        WB: begin
          pc <= pc_sel ? alu_q : pc4;
          bus.imem_req <= 1'b1;
          st <= FETCH;
        end
      endcase
    end
  end
`ifdef DATA_PATH_PERF_EN
  // free-running cycle and retired-instruction counters
  always_ff @(posedge clk) begin
    if (rest) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 64'd1;
      ret_cnt <= ret_cnt + 64'(retire);
    end
  end
`endif
endmodule

// File: tb/tb_data_path_mc.sv
// tb_data_path_mc: random instruction stream against a behavioural ISA-level model
module tb_data_path_mc;
  localparam logic [31:0] RPC = 32'h100;
  logic clk = 0, rest = 1;
  logic pc_sel = 0, a_sel = 0, b_sel = 0, RF_we = 0, mem_rd = 0, mem_wr = 0;
  logic [1:0] wb_sel = 0;
  logic [2:0] imm_sel = 0;
  logic [3:0] alu_sel = 0;
  logic [31:0] ins, pc;
  logic beq, retire;
  logic [1:0] state;
`ifdef DATA_PATH_PERF_EN
  logic [63:0] cyc_cnt, ret_cnt;
`endif
  data_path_mc_if bus ();
  data_path_mc #(.RESET_PC(RPC)) dut (
    .clk(clk), .rest(rest), .pc_sel(pc_sel), .a_sel(a_sel), .b_sel(b_sel), .RF_we(RF_we),
    .wb_sel(wb_sel), .imm_sel(imm_sel), .alu_sel(alu_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ins(ins), .pc(pc), .beq(beq), .retire(retire), .state(state),
`ifdef DATA_PATH_PERF_EN
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_rf [32];
  logic [31:0] m_pc, m_ld;
  longint m_cyc = 0, m_ret = 0;
  logic seen_beq;
  logic [7:0] seen_addr;
  logic [31:0] seen_wdata;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    m_cyc = rest ? 0 : m_cyc + 1;
    #1;
  endtask
  function automatic logic [31:0] rv(input logic [4:0] i);
    return i == 0 ? 32'd0 : m_rf[i];
  endfunction
  function automatic logic [31:0] m_imm(input logic [31:0] w, input logic [2:0] s);
    int v;
    v = signed'(w);
    case (s)
      3'd0: return 32'(v >>> 20);
      3'd1: return 32'((v >>> 25) * 32 + int'(w[11:7]));
      3'd2: return 32'((v >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
      3'd3: return w & 32'hFFFF_F000;
      3'd4: return 32'((v >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (op)
      4'd0: return 32'(sa + sb);
      4'd1: return 32'(sa - sb);
      4'd2: return 32'(longint'(a) * (64'd1 << b[4:0]));
      4'd3: return sa < sb ? 32'd1 : 32'd0;
      4'd4: return longint'(a) < longint'(b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return 32'(longint'(a) / (64'd1 << b[4:0]));
      4'd7: return 32'(sa >>> b[4:0]);
      4'd8: return a | b;
      4'd9: return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs, input logic [4:0] rd);
    return {im, rs, 3'b010, rd, 7'h03};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs, input logic [4:0] r2);
    return {im[11:5], r2, rs, 3'b010, im[4:0], 7'h23};
  endfunction
  task automatic run(input logic [31:0] w, input logic [3:0] op, input logic [2:0] is,
                     input logic ca, input logic cb, input logic cp, input logic cw, input logic [1:0] cs,
                     input logic mr, input logic mw, input int iw, input int dw, input logic [31:0] ld, input logic ab);
    logic [31:0] s1, s2, r, wbv;
    int n = 0;
    while (!bus.imem_req && n < 10) begin tick(); n++; end
    check("imem_req", bus.imem_req, 1);
    check("imem_addr", bus.imem_addr, m_pc);
    repeat (iw) begin
      bus.dmem_ready = 1'($urandom);
      tick();
      check("fetch_hold", {bus.imem_req, state, bus.dmem_req}, {1'b1, 2'd0, 1'b0});
    end
    bus.dmem_ready = 0;
    bus.imem_ready = 1;
    bus.imem_rdata = w;
    tick();
    bus.imem_ready = 0;
    bus.imem_rdata = $urandom;
    check("exec_state", state, 1);
    check("ir", ins, w);
    check("imem_req_drop", bus.imem_req, 0);
    {pc_sel, a_sel, b_sel, RF_we, wb_sel, imm_sel, alu_sel, mem_rd, mem_wr} = {cp, ca, cb, cw, cs, is, op, mr, mw};
    s1 = rv(w[19:15]);
    s2 = rv(w[24:20]);
    r = m_alu(op, ca ? m_pc : s1, cb ? m_imm(w, is) : s2);
    seen_beq = beq;
    check("beq", beq, s1 == s2);
    tick();
    if (mr | mw) begin
      check("mem_state", state, 2);
      check("dmem_req", bus.dmem_req, 1);
      check("dmem_we", bus.dmem_we, mw);
      check("dmem_addr", bus.dmem_addr, r[7:0]);
      check("dmem_wdata", bus.dmem_wdata, s2);
      seen_addr = bus.dmem_addr;
      seen_wdata = bus.dmem_wdata;
      if (ab) begin
        rest = 1;
        tick();
        rest = 0;
        check("abort_req", {bus.dmem_req, bus.imem_req}, 0);
        check("abort_state", state, 0);
        check("abort_retire", retire, 0);
        check("abort_pc", pc, RPC);
        check("abort_ir", ins, 32'h13);
        m_pc = RPC;
        m_ld = 0;
        m_ret = 0;
`ifdef DATA_PATH_PERF_EN
        check("abort_cyc", cyc_cnt, m_cyc);
        check("abort_ret", ret_cnt, 0);
`endif
        return;
      end
      repeat (dw) begin
        tick();
        check("mem_hold", {bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, retire}, {1'b1, mw, r[7:0], s2, 1'b0});
      end
      bus.dmem_ready = 1;
      bus.dmem_rdata = ld;
      tick();
      bus.dmem_ready = 0;
      bus.dmem_rdata = $urandom;
      if (!mw) m_ld = ld;
    end
    check("wb_state", state, 3);
    check("retire", retire, 1);
    check("wb_dmem_idle", bus.dmem_req, 0);
    wbv = cs[1] ? m_pc + 4 : cs[0] ? r : m_ld;
    if (cw && w[11:7] != 0) m_rf[w[11:7]] = wbv;
    m_pc = cp ? r : m_pc + 4;
    m_ret++;
    tick();
    check("retire_pulse", retire, 0);
    check("fetch_state", state, 0);
    check("pc", pc, m_pc);
    check("refetch_req", bus.imem_req, 1);
`ifdef DATA_PATH_PERF_EN
    check("cyc_cnt", cyc_cnt, m_cyc);
    check("ret_cnt", ret_cnt, m_ret);
`endif
  endtask
  initial begin
    bus.imem_ready = 0;
    bus.imem_rdata = 0;
    bus.dmem_ready = 0;
    bus.dmem_rdata = 0;
    m_pc = RPC;
    m_ld = 0;
    tick();
    tick();
    check("rst_pc", pc, RPC);
    check("rst_state", state, 0);
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_out", {bus.dmem_req, bus.dmem_we, retire}, 0);
    check("rst_ir", ins, 32'h13);
    rest = 0;
    tick();
    check("post_rst_req", bus.imem_req, 1);
    check("post_rst_addr", bus.imem_addr, 32'h100);
    run(enc_i(12'd5, 0, 1), 0, 0, 0, 1, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0);
    check("addi_pc", pc, 32'h104);
    run(32'hFE1086E3, 0, 2, 1, 1, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    check("beq_flag", seen_beq, 1);
    check("branch_target", bus.imem_addr, 32'h0F0);
    run({20'hDEADC, 5'd2, 7'h37}, 10, 3, 0, 1, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0);
    run(enc_i(12'hEEF, 2, 2), 0, 0, 0, 1, 0, 1, 2'b01, 0, 0, 1, 0, 0, 0);
    run(enc_s(12'h020, 0, 2), 0, 1, 0, 1, 0, 0, 2'b00, 0, 1, 0, 3, 0, 0);
    check("store_addr", seen_addr, 8'h20);
    check("store_data", seen_wdata, 32'hDEADBEEF);
    run(enc_i(12'h020, 0, 3), 0, 0, 0, 1, 0, 1, 2'b00, 1, 0, 0, 1, 32'h12345678, 0);
    run(enc_i(12'h020, 0, 0), 0, 0, 0, 1, 0, 1, 2'b00, 1, 0, 2, 0, 32'hCAFEF00D, 0);
    run(enc_s(12'h024, 0, 3), 0, 1, 0, 1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0);
    check("load_x3", seen_wdata, 32'h12345678);
    run(enc_s(12'h028, 0, 0), 0, 1, 0, 1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0);
    check("x0_zero", seen_wdata, 0);
    for (int i = 1; i < 32; i++)
      run(enc_i(12'($urandom), 0, 5'(i)), 0, 0, 0, 1, 0, 1, 2'b01, 0, 0, $urandom_range(0, 2), 0, 0, 0);
    for (int k = 0; k < 150; k++) begin
      int kind;
      logic mr, mw;
      kind = $urandom_range(0, 3);
      mw = kind == 3;
      mr = kind == 2 || (mw && $urandom_range(0, 3) == 0);
      run($urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 2'($urandom), mr, mw, $urandom_range(0, 2), $urandom_range(0, 3), $urandom, 0);
    end
    run(enc_i(12'h010, 0, 5), 0, 0, 0, 1, 0, 1, 2'b00, 1, 0, 0, 2, 32'h55AA55AA, 1);
    run(enc_s(12'h030, 0, 5), 0, 1, 0, 1, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0);
    check("abort_no_write", seen_wdata, m_rf[5]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
